hsem_task_dispatch: RTL

HSEM_TASK_DISPATCH -- requirements
Module: hsem_task_dispatch

---
 rtl/hsem_task_dispatch_pkg.sv | 12 +
 rtl/hsem_task_dispatch_rr_pick.sv | 27 ++
 rtl/hsem_task_dispatch.sv | 99 +++++++++
 3 files changed

// File: rtl/hsem_task_dispatch_pkg.sv
// Shared dispatch constants: task bitmap width, task index width and FSM state encodings.
package hsem_task_dispatch_pkg;

    localparam int TASK_SWITCH_WIDTH = 32;
    localparam int TASK_ID_WIDTH     = $clog2(TASK_SWITCH_WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } disp_state_e;

endpackage

// File: rtl/hsem_task_dispatch_rr_pick.sv
// hsem_rr_pick: combinational round-robin find-first; searches bitmap from pointer+1 upward, wrapping.
module hsem_rr_pick #(
    parameter int TASK_W = 32,
    parameter int ID_W   = 5
) (
    input  logic [TASK_W-1:0] bitmap,
    input  logic [ID_W-1:0]   pointer,
    output logic              found,
    output logic [ID_W-1:0]   index
);

    int unsigned pos;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = 0;
        for (int unsigned i = 1; i <= 32'(TASK_W); i++) begin
            pos = (32'(pointer) + i) % 32'(TASK_W);
            if (!found && bitmap[ID_W'(pos)]) begin
                found = 1'b1;
                index = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/hsem_task_dispatch.sv
// Round-robin dispatcher offering pending semaphore tasks to the core and tracking running ones.
// Optional macro HSEM_DISPATCH_IRQ_EN: irq becomes a registered |pend; otherwise irq is tied low.
module hsem_task_dispatch
    import hsem_task_dispatch_pkg::*;
#(
    parameter int TASK_W = TASK_SWITCH_WIDTH,
    parameter int ID_W   = TASK_ID_WIDTH
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [TASK_W-1:0] tsk_stat,
    output logic              tsk_vld,
    output logic [ID_W-1:0]   tsk_id,
    input  logic              tsk_rdy,
    input  logic              done_vld,
    input  logic [ID_W-1:0]   done_id,
    output logic [TASK_W-1:0] pend,
    output logic [TASK_W-1:0] run,
    output logic              busy,
    output logic              irq
);

    logic [TASK_W-1:0] stat_q;
    logic [TASK_W-1:0] new_req;
    logic [TASK_W-1:0] acc_mask;
    logic [TASK_W-1:0] done_mask;
    logic              armed;
    logic [ID_W-1:0]   rr_ptr;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              accept;
    disp_state_e       state;

    hsem_rr_pick #(
        .TASK_W (TASK_W),
        .ID_W   (ID_W)
    ) u_rr_pick (
        .bitmap  (pend),
        .pointer (rr_ptr),
        .found   (pick_found),
        .index   (pick_idx)
    );

    assign accept = tsk_vld & tsk_rdy;
    assign busy   = |run;

    // armed stays low for the first edge after reset so levels already high are not seen as edges;
    // an out-of-range done_id shifts the one-hot mask to zero and is ignored.
    always_comb begin
        new_req   = armed ? (tsk_stat & ~stat_q) : '0;
        acc_mask  = accept ? (TASK_W'(1) << tsk_id) : '0;
        done_mask = done_vld ? (TASK_W'(1) << done_id) : '0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            stat_q  <= '0;
            armed   <= 1'b0;
            pend    <= '0;
            run     <= '0;
            rr_ptr  <= ID_W'(TASK_W - 1);
            state   <= ST_IDLE;
            tsk_vld <= 1'b0;
            tsk_id  <= '0;
        end else begin
            stat_q <= tsk_stat;
            armed  <= 1'b1;
            pend   <= (pend & ~acc_mask) | new_req;
            run    <= (run & ~done_mask) | acc_mask;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        tsk_id  <= pick_idx;
                        tsk_vld <= 1'b1;
                        state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (tsk_rdy) begin
                        rr_ptr  <= tsk_id;
                        tsk_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HSEM_DISPATCH_IRQ_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) irq <= 1'b0;
        else          irq <= |pend;
    end
`else
    assign irq = 1'b0;
`endif

endmodule
